// File: rtl/vecmat_pkg.sv
// rtl/vecmat_pkg.sv - shared sizes, FSM encoding and saturating add for vecmat_add_sched
package vecmat_pkg;

   localparam int ARRAYSIZE     = 1024;
   localparam int DWIDTH        = 16;
   localparam int TREE_LAT      = 2;
   localparam int OUT_AWIDTH    = 9;
   localparam int ROWS_PER_PASS = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Returns {overflow, clamped signed sum}.
   function automatic logic [DWIDTH:0] sat_add(input logic [DWIDTH-1:0] a,
                                                input logic [DWIDTH-1:0] b);
      logic [DWIDTH-1:0] s;
      s = a + b;
      if (a[DWIDTH-1] == b[DWIDTH-1] && s[DWIDTH-1] != a[DWIDTH-1])
         return {1'b1, a[DWIDTH-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}}};
      return {1'b0, s};
   endfunction

endpackage

// File: rtl/vecmat_add_sched_rr_arb.sv
// rtl/vecmat_add_sched_rr_arb.sv - 2-way round-robin pick; pointer moves past the requester whose row completed
module vecmat_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       done_id,
   output logic       pick
);

   logic rr_ptr;

   always_comb begin
      pick = rr_ptr;
      if (!req[rr_ptr])
         pick = ~rr_ptr;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         rr_ptr <= 1'b0;
      else if (update)
         rr_ptr <= ~done_id;
   end

endmodule

// File: rtl/vecmat_add_sched.sv
// rtl/vecmat_add_sched.sv - adder-tree scheduler: arbitrate, feed chunks, accumulate rows, write sums
// Optional VECMAT_SAT_EN: signed-saturating accumulation plus sat_flag output.
module vecmat_add_sched
   import vecmat_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_last,
   input  logic [ARRAYSIZE-1:0]  req_data0,
   input  logic [ARRAYSIZE-1:0]  req_data1,
   output logic [1:0]            req_ready,
   output logic [ARRAYSIZE-1:0]  tree_in,
   input  logic [DWIDTH-1:0]     tree_sum,
   output logic                  wr_en,
   output logic [OUT_AWIDTH-1:0] wr_addr,
   output logic [DWIDTH-1:0]     wr_data,
   output logic                  wr_id,
   output logic                  busy,
   output logic                  done
`ifdef VECMAT_SAT_EN
   ,
   output logic                  sat_flag
`endif
);

   localparam int RCW = $clog2(ROWS_PER_PASS);
   localparam logic [RCW-1:0] ROW_LAST = RCW'(ROWS_PER_PASS - 1);

   state_t            state;
   logic              grant;
   logic              pick;
   logic [TREE_LAT:0] vpipe;
   logic [TREE_LAT:0] lastpipe;
   logic [DWIDTH-1:0] acc;
   logic [DWIDTH-1:0] acc_next;
   logic [RCW-1:0]    row_cnt;
   logic              accept;
   logic              accept_last;
   logic              tap;
   logic              tap_last;
`ifdef VECMAT_SAT_EN
   logic              ovf;
   logic              row_sat;
`endif

   assign accept      = req_valid[grant] & req_ready[grant];
   assign accept_last = accept & req_last[grant];
   assign tap         = vpipe[TREE_LAT];
   assign tap_last    = tap & lastpipe[TREE_LAT];

   always_comb begin
`ifdef VECMAT_SAT_EN
      {ovf, acc_next} = sat_add(acc, tree_sum);
`else
      acc_next = acc + tree_sum;
`endif
   end

   vecmat_rr_arb u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .update  (accept_last),
      .done_id (grant),
      .pick    (pick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         grant     <= 1'b0;
         tree_in   <= '0;
         vpipe     <= '0;
         lastpipe  <= '0;
         acc       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_id     <= 1'b0;
         req_ready <= 2'b00;
         done      <= 1'b0;
         busy      <= 1'b0;
         row_cnt   <= '0;
`ifdef VECMAT_SAT_EN
         row_sat   <= 1'b0;
         sat_flag  <= 1'b0;
`endif
      end else begin
         vpipe    <= {vpipe[TREE_LAT-1:0], accept};
         lastpipe <= {lastpipe[TREE_LAT-1:0], accept_last};
         if (accept)
            tree_in <= grant ? req_data1 : req_data0;

         wr_en <= 1'b0;
         done  <= 1'b0;
`ifdef VECMAT_SAT_EN
         sat_flag <= 1'b0;
`endif
         if (tap) begin
            if (tap_last) begin
               wr_data <= acc_next;
               wr_en   <= 1'b1;
               wr_id   <= grant;
               acc     <= '0;
`ifdef VECMAT_SAT_EN
               sat_flag <= row_sat | ovf;
               row_sat  <= 1'b0;
`endif
            end else begin
               acc <= acc_next;
`ifdef VECMAT_SAT_EN
               row_sat <= row_sat | ovf;
`endif
            end
         end

         // Address and pass counter advance on the strobe cycle itself.
         if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
            if (row_cnt == ROW_LAST) begin
               row_cnt <= '0;
               done    <= 1'b1;
            end else begin
               row_cnt <= row_cnt + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant     <= pick;
                  req_ready <= pick ? 2'b10 : 2'b01;
                  busy      <= 1'b1;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               if (accept_last) begin
                  req_ready <= 2'b00;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (tap_last) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
